// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register, async instruction memory read,
// and IF/ID register with address-error flagging and fetch counting.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic [31:0] instr,
  output logic [9:0]  addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        exc_adel,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  // 33-bit bound so the window end never wraps
  localparam logic [32:0] PC_LIM =
    {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_d;
  logic [31:0] ir_d;
  logic [31:0] ir_pc_d;
  logic        ir_valid_d;
  logic        exc_adel_d;
  logic [31:0] fetch_cnt_d;
  logic        legal;

  assign addr = pc[11:2];

  assign legal = (pc[1:0] == 2'b00)
              && (pc >= PC_RESET)
              && ({1'b0, pc} < PC_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc        <= PC_RESET;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      exc_adel  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      ir_pc     <= ir_pc_d;
      ir_valid  <= ir_valid_d;
      exc_adel  <= exc_adel_d;
      fetch_cnt <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    ir_d        = ir;
    ir_pc_d     = ir_pc;
    ir_valid_d  = ir_valid;
    exc_adel_d  = exc_adel;
    fetch_cnt_d = fetch_cnt;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // redirect wins over stall so it is never lost
        if (br_valid) begin
          pc_d       = br_target;
          ir_d       = '0;
          ir_valid_d = 1'b0;
          exc_adel_d = 1'b0;
        end else if (!stall) begin
          pc_d        = pc + 32'd4;
          ir_d        = legal ? instr : '0;
          ir_pc_d     = pc;
          ir_valid_d  = 1'b1;
          exc_adel_d  = !legal;
          fetch_cnt_d = fetch_cnt + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and random checks of ifu_fetch against a
// transaction-level fetch model kept in the bench.
module tb_ifu_fetch;

  localparam longint BASE  = 64'h3000;
  localparam longint WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] instr;
  logic [9:0]  addr;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        exc_adel;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_ir_pc;
  logic        m_v;
  logic        m_exc;
  logic [31:0] m_cnt;

  ifu_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .instr     (instr),
    .addr      (addr),
    .pc        (pc),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .exc_adel  (exc_adel),
    .fetch_cnt (fetch_cnt)
  );

  assign instr = mem[addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    longint word;
    word = (longint'(m_pc) / 4) % WORDS;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".addr"}, 32'(addr), 32'(word));
    chk({tag, ".ir"}, ir, m_ir);
    chk({tag, ".ir_pc"}, ir_pc, m_ir_pc);
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_v));
    chk({tag, ".exc_adel"}, 32'(exc_adel), 32'(m_exc));
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_pc    = 32'(BASE);
    m_ir    = 0;
    m_ir_pc = 0;
    m_v     = 0;
    m_exc   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    longint p;
    bit     ok;
    p  = longint'(m_pc);
    ok = (p % 4 == 0) && (p >= BASE)
      && (p < BASE + 4 * WORDS);
    if (!m_run) begin
      m_run = 1;
    end else if (br_valid) begin
      m_pc  = br_target;
      m_ir  = 0;
      m_v   = 0;
      m_exc = 0;
    end else if (!stall) begin
      m_ir    = ok ? mem[(p - BASE) / 4] : 32'h0;
      m_ir_pc = m_pc;
      m_v     = 1;
      m_exc   = !ok;
      m_pc    = 32'((p + 4) % (64'd1 << 32));
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic step(input string tag,
                      input logic s,
                      input logic b,
                      input logic [31:0] t);
    stall     = s;
    br_valid  = b;
    br_target = t;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] tgt;
    int          r;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2401_0001;
    mem[1] = 32'h2402_0002;
    mem[2] = 32'h0022_1820;
    stall     = 1;
    br_valid  = 1;
    br_target = 32'h1234_5678;
    reset     = 1;
    model_reset();
    #3;
    chk_all("reset");
    @(negedge clk);
    reset = 0;

    step("boot", 0, 0, 0);
    step("cap1", 0, 0, 0);
    chk("cap1.first_ir", ir, 32'h2401_0001);
    step("cap2", 0, 0, 0);
    step("stall1", 1, 0, 0);
    step("stall2", 1, 0, 0);
    step("resume", 0, 0, 0);
    chk("resume.ir_pc", ir_pc, 32'h3008);
    chk("resume.cnt", fetch_cnt, 32'd3);

    step("br_stall", 1, 1, 32'h3040);
    step("br_after", 0, 0, 0);
    step("br_mis", 0, 1, 32'h3002);
    step("mis_cap", 0, 0, 0);
    chk("mis_cap.pc", pc, 32'h3006);
    step("br_end", 0, 1, 32'h3FFC);
    step("end_last", 0, 0, 0);
    step("end_over", 0, 0, 0);
    step("br_wrap", 0, 1, 32'hFFFF_FFFC);
    step("wrap_cap", 0, 0, 0);
    chk("wrap_cap.pc", pc, 32'h0);
    step("br_low", 0, 1, 32'h2FFC);
    step("low_cap", 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: tgt = 32'h3000 + ($urandom_range(0, 1023) << 2);
        1: tgt = 32'h3FF0 + $urandom_range(0, 31);
        2: tgt = $urandom;
        default: tgt = 32'h3000 + $urandom_range(0, 4095);
      endcase
      step("rand",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           tgt);
    end

    step("br_3010", 0, 1, 32'h3010);
    step("at_3010", 1, 0, 0);
    @(negedge clk);
    #2;
    reset = 1;
    model_reset();
    #1;
    chk_all("async_rst");
    stall    = 1;
    br_valid = 1;
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk);
    reset = 0;
    step("reboot", 1, 1, 32'h3100);
    step("recap", 0, 0, 0);
    step("recap2", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
